// File: rtl/mult_div_seq.sv
// Multi-cycle signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide share one 2*WIDTH+1 bit accumulator; results land in hi/lo on the fix-up edge.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int ACC_W = 2 * WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DZ   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;

    logic [WIDTH:0]     booth_base_d;
    logic [WIDTH:0]     booth_sum_d;
    logic [ACC_W-1:0]   booth_next_d;
    logic [WIDTH:0]     div_rem_sh_d;
    logic [WIDTH:0]     div_trial_d;
    logic [ACC_W-1:0]   div_next_d;
    logic [WIDTH-1:0]   fix_hi_d;
    logic [WIDTH-1:0]   fix_lo_d;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    // Datapath step: one Booth iteration, one restoring-divide iteration, and the sign fix-up.
    always_comb begin
        // Booth add is one bit wider so a most-negative multiplicand cannot overflow before the shift
        booth_base_d = {acc_q[ACC_W-1], acc_q[ACC_W-1:WIDTH+1]};
        booth_sum_d  = booth_base_d;
        case (acc_q[1:0])
            2'b01:   booth_sum_d = booth_base_d + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   booth_sum_d = booth_base_d - {opnd_q[WIDTH-1], opnd_q};
            default: booth_sum_d = booth_base_d;
        endcase
        booth_next_d = {booth_sum_d, acc_q[WIDTH:1]};

        div_rem_sh_d = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial_d  = div_rem_sh_d - {1'b0, opnd_q};
        if (!div_trial_d[WIDTH]) begin
            div_next_d = {div_trial_d, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next_d = {div_rem_sh_d, acc_q[WIDTH-2:0], 1'b0};
        end

        if (op_q) begin
            fix_lo_d = neg_quo_q ? negate(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            fix_hi_d = neg_rem_q ? negate(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            fix_lo_d = acc_q[WIDTH:1];
            fix_hi_d = acc_q[ACC_W-1:WIDTH+1];
        end
    end

    // Control FSM with registered result and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= {ACC_W{1'b0}};
            opnd_q     <= {WIDTH{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            op_q       <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        op_q       <= op;
                        cnt_q      <= {CNT_W{1'b0}};
                        neg_quo_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_q  <= a[WIDTH-1];
                        if (!op) begin
                            acc_q   <= {{WIDTH{1'b0}}, b, 1'b0};
                            opnd_q  <= a;
                            state_q <= S_MUL;
                        end else if (b == {WIDTH{1'b0}}) begin
                            state_q <= S_DZ;
                        end else begin
                            acc_q   <= {{(WIDTH+1){1'b0}}, abs_val(a)};
                            opnd_q  <= abs_val(b);
                            state_q <= S_DIV;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_q <= booth_next_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_MUL;
                    end
                end
                S_DIV: begin
                    acc_q <= div_next_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DZ: begin
                    div_zero_q <= 1'b1;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: hand-computed results, latency, busy and reset behaviour.
module tb_mult_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int pass_cnt;
    int total_cnt;

    mult_div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns at the negedge after edge 0.
    task automatic start_op(input logic top, input logic [31:0] ta, input logic [31:0] tbv);
        @(negedge clk);
        start = 1'b1;
        op    = top;
        a     = ta;
        b     = tbv;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        op    = ~top;
    endtask

    // Wait (bounded) for done; n counts edges seen since the call, busy_ok tracks busy shape.
    task automatic wait_done(output int n, output logic busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end else if (busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check32("reset_hi", hi, 32'h0);
        check32("reset_lo", lo, 32'h0);
        check32("reset_flags", {29'h0, busy, done, div_zero}, 32'h0);
    endtask

    task automatic test_mult();
        int n;
        logic bok;
        start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        check32("mult_busy_edge0", {31'h0, busy}, 32'h1);
        wait_done(n, bok);
        check_int("mult_latency", n, 33);
        check32("mult_busy_shape", {31'h0, bok}, 32'h1);
        check32("mult_hi", hi, 32'hFFFF_FFFF);
        check32("mult_lo", lo, 32'hFFFF_FFEB);
        @(negedge clk);
        check32("mult_done_pulse", {31'h0, done}, 32'h0);
    endtask

    task automatic test_div();
        int n;
        logic bok;
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, bok);
        check_int("div1_latency", n, 33);
        check32("div1_lo", lo, 32'hFFFF_FFFD);
        check32("div1_hi", hi, 32'hFFFF_FFFF);
        check32("div1_dz", {31'h0, div_zero}, 32'h0);
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(n, bok);
        check32("div2_lo", lo, 32'hFFFF_FFFD);
        check32("div2_hi", hi, 32'h0000_0001);
    endtask

    task automatic test_div_zero();
        int n;
        logic bok;
        start_op(1'b0, 32'd3, 32'd5);
        wait_done(n, bok);
        check32("pre_lo", lo, 32'd15);
        start_op(1'b1, 32'd5, 32'd0);
        wait_done(n, bok);
        check_int("dz_latency", n, 1);
        check32("dz_flag", {31'h0, div_zero}, 32'h1);
        check32("dz_hi", hi, 32'h0);
        check32("dz_lo", lo, 32'd15);
        repeat (3) @(negedge clk);
        check32("dz_held", {31'h0, div_zero}, 32'h1);
        start_op(1'b0, 32'd2, 32'd9);
        check32("dz_cleared", {31'h0, div_zero}, 32'h0);
        wait_done(n, bok);
        check32("dz_next_lo", lo, 32'd18);
    endtask

    task automatic test_corners();
        int n;
        logic bok;
        start_op(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(n, bok);
        check32("minmin_hi", hi, 32'h4000_0000);
        check32("minmin_lo", lo, 32'h0);
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bok);
        check32("ovf_lo", lo, 32'h8000_0000);
        check32("ovf_hi", hi, 32'h0);
        check32("ovf_dz", {31'h0, div_zero}, 32'h0);
        start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, bok);
        check32("m1m1_hi", hi, 32'h0);
        check32("m1m1_lo", lo, 32'h1);
    endtask

    task automatic test_busy_ignore();
        int n;
        logic bok;
        start_op(1'b0, 32'h0001_2345, 32'h0000_0100);
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd99;
        b     = 32'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bok);
        check_int("ignore_latency", n, 23);
        check32("ignore_lo", lo, 32'h0123_4500);
        check32("ignore_hi", hi, 32'h0);
        check32("ignore_dz", {31'h0, div_zero}, 32'h0);
    endtask

    task automatic test_reset_mid();
        int n;
        logic bok;
        logic seen;
        start_op(1'b1, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check32("rstmid_lo", lo, 32'h0);
        check32("rstmid_hi", hi, 32'h0);
        check32("rstmid_busy", {30'h0, busy, done}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check32("rstmid_no_done", {31'h0, seen}, 32'h0);
        start_op(1'b0, 32'd6, 32'd7);
        wait_done(n, bok);
        check32("after_rst_lo", lo, 32'd42);
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd2;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check32("done_start_busy", {31'h0, busy}, 32'h0);
        repeat (4) @(negedge clk);
        check32("done_start_quiet", {30'h0, busy, done}, 32'h0);
        check32("done_start_lo", lo, 32'd42);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_corners();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Multi-cycle signed multiply/divide unit for the multi-cycle MIPS datapath.
- Sits between the A/B operand registers (upstream) and the HI/LO registers (downstream).
- The control FSM pulses start with an operation select and then waits on done.
- Results are presented on hi/lo, ready for the HI/LO register write enables.

Parameters:
- WIDTH, 32, operand width. Product and remainder/quotient pair are 2*WIDTH bits split into hi/lo.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  1  0 = signed multiply (mult), 1 = signed divide (div).
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- hi  output  WIDTH  mult: product[63:32]; div: remainder.
- lo  output  WIDTH  mult: product[31:0]; div: quotient.
- busy  output  1  high from the edge accepting start until the edge raising done.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  divide-by-zero flag; held until the next accepted start or rst.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst is sampled high, all of the following take effect on that edge:
  - hi, lo, busy, done, div_zero and all internal registers go to 0.
  - The FSM goes to IDLE.
  - rst overrides any in-flight operation; the result is discarded and no done is produced.
- States: IDLE, MUL, DIV, FIX, DZ, DONE.
- IDLE:
  - If start=1, a and b are latched on that edge (call it edge 0) and busy becomes 1.
  - div_zero is cleared on edge 0.
  - Next state: op=0 → MUL; op=1 and b≠0 → DIV; op=1 and b=0 → DZ.
  - Later changes to a, b and op are ignored until the next start.
- MUL:
  - Radix-2 Booth over a 2*WIDTH+1-bit accumulator, one iteration per cycle.
  - Iteration counter runs WIDTH cycles (edges 1..32), then → FIX.
- DIV:
  - Restoring division on |a| and |b|, one quotient bit per cycle.
  - Edges 1..32, then → FIX.
  - Operand signs are recorded at edge 0.
- FIX (edge 33):
  - mult: hi/lo are loaded with the 64-bit two's-complement product.
  - div: quotient is negated if sign(a)≠sign(b); remainder is negated if a<0. Truncation is toward zero; the remainder takes the dividend's sign.
  - Then → DONE.
  - hi/lo are written on this edge only.
- DONE:
  - done=1 for the single cycle following edge 33; busy falls on edge 33.
  - Next edge → IDLE.
  - A start sampled during DONE is ignored.
  - Fixed latency: done is high in the cycle after edge WIDTH+1 (34 edges incl. edge 0 of start).
- DZ:
  - Entered at edge 0; edge 1 → DONE with div_zero=1.
  - hi/lo are left unchanged.
  - done is high in the cycle after edge 1.
- start while busy=1 (MUL/DIV/FIX/DZ) is ignored entirely; no queueing.
- Overflow case: a=0x80000000, b=0xFFFFFFFF (div) gives lo=0x80000000 (wrapped), hi=0, div_zero=0. No trap is raised; that is the control unit's concern.
- hi/lo hold their values indefinitely between operations.

Test Plan:
- Reset then mult: rst for 2 cycles, start op=0 a=7 b=0xFFFFFFFD.
  - Expect hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - done is a single pulse 34 edges after start; busy is high for edges 0..32.
- Signed div: a=0xFFFFFFF9 (-7), b=2.
  - Expect lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
  - Also a=7, b=0xFFFFFFFE gives lo=0xFFFFFFFD, hi=1.
- Divide by zero: preload hi/lo via a mult of 3*5 (lo=15), then div a=5 b=0.
  - done is high 2 edges after start, div_zero=1, hi=0, lo=15 unchanged.
  - Next accepted start clears div_zero.
- Corners:
  - mult 0x80000000*0x80000000 gives hi=0x40000000, lo=0.
  - div 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
  - mult 0xFFFFFFFF*0xFFFFFFFF gives hi=0, lo=1.
- Busy and reset interaction:
  - A start pulse with different operands at edge 10 of a running mult is ignored; the original result is unchanged.
  - rst at edge 15 of a div gives hi=lo=0 next cycle, busy=0, no done pulse.
  - A subsequent mult 6*7 gives lo=42.
